// File: rtl/sigmoid_pkg.sv
// Shared constants, fixed-point type and rounding helper for the sigmoid datapath.
// Rounding is enabled by defining SIGMOID_BWD_ROUND_EN (default build: floor).
package sigmoid_pkg;

   localparam int DATA_W = 32;
   localparam int FRAC_W = 16;

   typedef logic signed [DATA_W-1:0] fxp_t;

   localparam fxp_t ONE = fxp_t'(1 << FRAC_W);

`ifdef SIGMOID_BWD_ROUND_EN
   localparam bit ROUND_EN = 1'b1;
`else
   localparam bit ROUND_EN = 1'b0;
`endif

   // Half an LSB of the shifted result when rounding, otherwise zero (floor).
   function automatic logic [63:0] round_const(input int frac_w);
      return ROUND_EN ? (64'd1 << (frac_w - 1)) : 64'd0;
   endfunction

endpackage

// File: rtl/fxp_mul_shift.sv
// Signed multiply, optional half-LSB rounding add, arithmetic right shift by FRAC_W.
// Rounding follows SIGMOID_BWD_ROUND_EN through sigmoid_pkg::round_const.
module fxp_mul_shift #(
   parameter int A_W    = 18,
   parameter int B_W    = 18,
   parameter int FRAC_W = 16,
   parameter int OUT_W  = 17
)(
   input  logic signed [A_W-1:0]   i_a,
   input  logic signed [B_W-1:0]   i_b,
   output logic signed [OUT_W-1:0] o_y
);
   import sigmoid_pkg::*;

   // One guard bit above the full product so the rounding add cannot wrap.
   localparam int P_W = A_W + B_W + 1;
   localparam logic signed [P_W-1:0] RND = P_W'(round_const(FRAC_W));

   logic signed [P_W-1:0] w_prod;
   logic signed [P_W-1:0] w_sum;
   logic signed [P_W-1:0] w_shift;
   logic                  w_unused;

   assign w_prod  = P_W'(i_a) * P_W'(i_b);
   assign w_sum   = w_prod + RND;
   assign w_shift = w_sum >>> FRAC_W;
   assign o_y     = w_shift[OUT_W-1:0];

   // Callers size OUT_W so that the discarded top bits are pure sign extension.
   assign w_unused = ^w_shift[P_W-1:OUT_W];

endmodule

// File: rtl/sigmoid_backward.sv
// Sigmoid backward pass: dx = dy * y * (1 - y), 3-stage valid/ready pipeline.
// Define SIGMOID_BWD_ROUND_EN for round-half-up shifts; default build floors.
module sigmoid_backward #(
   parameter int DATA_W = sigmoid_pkg::DATA_W,
   parameter int FRAC_W = sigmoid_pkg::FRAC_W
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_y,
   input  logic signed [DATA_W-1:0] in_dy,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_dx,
   output logic                     out_clamp
);

   // yc and 1-yc live in [0, ONE], which needs FRAC_W+1 unsigned bits.
   localparam int YC_W = FRAC_W + 1;
   localparam logic signed [DATA_W-1:0] L_ONE    = DATA_W'(1) << FRAC_W;
   localparam logic        [YC_W-1:0]   L_ONE_YC = YC_W'(1) << FRAC_W;

   logic                     w_ready1;
   logic                     w_ready2;
   logic                     w_ready3;

   logic                     w_y_neg;
   logic                     w_y_big;
   logic                     w_clamp;
   logic        [YC_W-1:0]   w_yc;
   logic        [YC_W-1:0]   w_omy;
   logic signed [YC_W-1:0]   w_p;
   logic signed [DATA_W-1:0] w_dx;

   logic                     r_v1;
   logic        [YC_W-1:0]   r_yc1;
   logic        [YC_W-1:0]   r_omy1;
   logic signed [DATA_W-1:0] r_dy1;
   logic                     r_clamp1;

   logic                     r_v2;
   logic        [YC_W-1:0]   r_p2;
   logic signed [DATA_W-1:0] r_dy2;
   logic                     r_clamp2;

   logic                     r_v3;
   logic signed [DATA_W-1:0] r_dx3;
   logic                     r_clamp3;

   // A stage may load when empty or when the stage after it is loading.
   assign w_ready3 = !r_v3 || out_ready;
   assign w_ready2 = !r_v2 || w_ready3;
   assign w_ready1 = !r_v1 || w_ready2;

   assign w_y_neg = in_y[DATA_W-1];
   assign w_y_big = in_y > L_ONE;
   assign w_clamp = w_y_neg || w_y_big;

   always_comb begin
      w_yc = in_y[YC_W-1:0];
      if (w_y_neg) begin
         w_yc = '0;
      end else if (w_y_big) begin
         w_yc = L_ONE_YC;
      end
   end

   assign w_omy = L_ONE_YC - w_yc;

   // Stage 2 product: both factors are non-negative, so zero-extend into the signed multiplier.
   fxp_mul_shift #(
      .A_W    (YC_W + 1),
      .B_W    (YC_W + 1),
      .FRAC_W (FRAC_W),
      .OUT_W  (YC_W)
   ) u_mul_p (
      .i_a (signed'({1'b0, r_yc1})),
      .i_b (signed'({1'b0, r_omy1})),
      .o_y (w_p)
   );

   // p <= ONE/4, so |dx| <= |dy|/4 and the low DATA_W bits always hold the result.
   fxp_mul_shift #(
      .A_W    (DATA_W),
      .B_W    (YC_W + 1),
      .FRAC_W (FRAC_W),
      .OUT_W  (DATA_W)
   ) u_mul_dx (
      .i_a (r_dy2),
      .i_b (signed'({1'b0, r_p2})),
      .o_y (w_dx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1     <= 1'b0;
         r_yc1    <= '0;
         r_omy1   <= '0;
         r_dy1    <= '0;
         r_clamp1 <= 1'b0;
         r_v2     <= 1'b0;
         r_p2     <= '0;
         r_dy2    <= '0;
         r_clamp2 <= 1'b0;
         r_v3     <= 1'b0;
         r_dx3    <= '0;
         r_clamp3 <= 1'b0;
      end else begin
         if (w_ready1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
               r_yc1    <= w_yc;
               r_omy1   <= w_omy;
               r_dy1    <= in_dy;
               r_clamp1 <= w_clamp;
            end
         end
         if (w_ready2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
               r_p2     <= w_p;
               r_dy2    <= r_dy1;
               r_clamp2 <= r_clamp1;
            end
         end
         // Output registers only change on a real load, so they hold under backpressure.
         if (w_ready3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
               r_dx3    <= w_dx;
               r_clamp3 <= r_clamp2;
            end
         end
      end
   end

   assign in_ready  = w_ready1;
   assign out_valid = r_v3;
   assign out_dx    = r_dx3;
   assign out_clamp = r_clamp3;

endmodule

// File: tb/tb_sigmoid_backward.sv
// Self-checking bench for sigmoid_backward: vector table, random stream, backpressure, reset.
// Expected values follow SIGMOID_BWD_ROUND_EN the same way the design build does.
module tb_sigmoid_backward;
   import sigmoid_pkg::*;

`ifdef SIGMOID_BWD_ROUND_EN
   localparam bit RND_EN = 1'b1;
`else
   localparam bit RND_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_y = '0;
   logic [31:0] in_dy = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_dx;
   logic        out_clamp;

   always #5 clk = ~clk;

   sigmoid_backward dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_y      (in_y),
      .in_dy     (in_dy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_dx    (out_dx),
      .out_clamp (out_clamp)
   );

   typedef struct {
      logic [31:0] dx;
      logic        cl;
   } exp_t;

   typedef struct {
      logic [31:0] y;
      logic [31:0] dy;
      logic [31:0] dx;
      logic        cl;
   } vec_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] cur_dx;
   logic        cur_cl;
   bit          rand_bp = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Reference arithmetic straight from the formula, in 64-bit signed integers.
   function automatic void model(input logic [31:0] y, input logic [31:0] dy,
                                 output logic [31:0] dx, output logic cl);
      longint ys, ds, yc, omy, p, d, r;
      ys  = $signed(y);
      ds  = $signed(dy);
      r   = RND_EN ? 64'sd32768 : 64'sd0;
      cl  = (ys < 0) || (ys > 65536);
      yc  = (ys < 0) ? 0 : ((ys > 65536) ? 65536 : ys);
      omy = 65536 - yc;
      p   = (yc * omy + r) >>> 16;
      d   = (ds * p + r) >>> 16;
      dx  = d[31:0];
   endfunction

   // One clock: sample just after the inputs settle, score any transfers, advance to the next negedge.
   task automatic tick(output bit acc);
      exp_t e;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out: got out_dx=%h with no result outstanding, required none", out_dx);
         end else begin
            e = sb.pop_front();
            $display("out dx=%h clamp=%b (req dx=%h clamp=%b)", out_dx, out_clamp, e.dx, e.cl);
            check("dx", out_dx, e.dx);
            check("clamp", {31'b0, out_clamp}, {31'b0, e.cl});
         end
      end
      if (acc) begin
         e.dx = cur_dx;
         e.cl = cur_cl;
         sb.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_exp(input logic [31:0] y, input logic [31:0] dy,
                            input logic [31:0] dx, input logic cl);
      in_y     = y;
      in_dy    = dy;
      in_valid = 1'b1;
      cur_dx   = dx;
      cur_cl   = cl;
   endtask

   task automatic send(input logic [31:0] y, input logic [31:0] dy,
                       input logic [31:0] dx, input logic cl);
      bit acc;
      acc = 1'b0;
      drive_exp(y, dy, dx, cl);
      for (int k = 0; k < 40 && !acc; k++) tick(acc);
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready stuck low, required accept of y=%h", y);
      end
   endtask

   task automatic drain();
      bit acc;
      in_valid = 1'b0;
      rand_bp  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 60 && sb.size() != 0; k++) tick(acc);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d results outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic lat_check(input logic [31:0] y, input logic [31:0] dy,
                            input logic [31:0] dx, input logic cl);
      bit acc;
      int edges;
      send(y, dy, dx, cl);
      in_valid = 1'b0;
      edges = 1;
      while (!out_valid && edges < 8) begin
         tick(acc);
         edges++;
      end
      check("latency", 32'(edges), 32'd3);
      drain();
   endtask

   vec_t        tbl[13];
   vec_t        bp_items[5];
   logic [31:0] snap;
   bit          have_snap;
   int          accepted;
   bit          acc;
   logic [31:0] ry, rdy, mdx;
   logic        mcl;

   initial begin
      tbl[0]  = '{32'h0000_8000, 32'h0001_0000, 32'h0000_4000, 1'b0};
      tbl[1]  = '{32'h0000_8000, 32'hFFFE_0000, 32'hFFFF_8000, 1'b0};
      tbl[2]  = '{32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 1'b0};
      tbl[3]  = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0};
      tbl[4]  = '{32'hFFFF_FFFB, 32'h0001_0000, 32'h0000_0000, 1'b1};
      tbl[5]  = '{32'h0001_8000, 32'h0001_0000, 32'h0000_0000, 1'b1};
      tbl[6]  = '{32'h0000_0001, 32'h0001_0000, RND_EN ? 32'h1 : 32'h0, 1'b0};
      tbl[7]  = '{32'h0000_4000, 32'h0001_0000, 32'h0000_3000, 1'b0};
      tbl[8]  = '{32'h0000_4000, 32'hFFFF_FFFF, RND_EN ? 32'h0 : 32'hFFFF_FFFF, 1'b0};
      tbl[9]  = '{32'h8000_0000, 32'h0001_2345, 32'h0000_0000, 1'b1};
      tbl[10] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      tbl[11] = '{32'h0000_C000, 32'h7FFF_FFFF, RND_EN ? 32'h1800_0000 : 32'h17FF_FFFF, 1'b0};
      tbl[12] = '{32'h0000_C000, 32'h8000_0000, 32'hE800_0000, 1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_dx", out_dx, 32'd0);
      check("rst_out_clamp", {31'b0, out_clamp}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Latency of a single item with no backpressure
      lat_check(32'h8000, 32'h10000, 32'h4000, 1'b0);

      // Vector table streamed back to back
      foreach (tbl[i]) send(tbl[i].y, tbl[i].dy, tbl[i].dx, tbl[i].cl);
      drain();

      // Random stream with random output stalls
      rand_bp = 1'b1;
      for (int i = 0; i < 30; i++) begin
         ry  = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 32'h10000));
         rdy = $urandom();
         model(ry, rdy, mdx, mcl);
         send(ry, rdy, mdx, mcl);
      end
      drain();

      // Backpressure: five items against a stalled output
      for (int i = 0; i < 5; i++) begin
         bp_items[i].y  = 32'h1000 * 32'(i + 1);
         bp_items[i].dy = 32'h10000 * 32'(i + 1);
         model(bp_items[i].y, bp_items[i].dy, bp_items[i].dx, bp_items[i].cl);
      end
      out_ready = 1'b0;
      accepted  = 0;
      have_snap = 1'b0;
      for (int c = 0; c < 8; c++) begin
         drive_exp(bp_items[accepted].y, bp_items[accepted].dy,
                   bp_items[accepted].dx, bp_items[accepted].cl);
         tick(acc);
         if (acc) accepted++;
         if (out_valid) begin
            if (have_snap) check("hold_dx", out_dx, snap);
            else begin
               snap      = out_dx;
               have_snap = 1'b1;
            end
         end
      end
      check("bp_accepts", 32'(accepted), 32'd3);
      check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      out_ready = 1'b1;
      #1;
      check("drain_in_ready", {31'b0, in_ready}, 32'd1);
      tick(acc);
      check("b2b_accept", {31'b0, acc}, 32'd1);
      if (acc) accepted++;
      for (int c = 0; c < 10 && accepted < 5; c++) begin
         drive_exp(bp_items[accepted].y, bp_items[accepted].dy,
                   bp_items[accepted].dx, bp_items[accepted].cl);
         tick(acc);
         if (acc) accepted++;
      end
      check("bp_total_accepts", 32'(accepted), 32'd5);
      drain();

      // Asynchronous reset with two items in flight
      send(32'h8000, 32'h10000, 32'h4000, 1'b0);
      send(32'h4000, 32'h10000, 32'h3000, 1'b0);
      in_valid = 1'b0;
      tick(acc);
      check("pre_reset_valid", {31'b0, out_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", {31'b0, out_valid}, 32'd0);
      check("async_rst_dx", out_dx, 32'd0);
      check("async_rst_clamp", {31'b0, out_clamp}, 32'd0);
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick(acc);
         check("no_stale_valid", {31'b0, out_valid}, 32'd0);
      end
      lat_check(32'h4000, 32'h20000, 32'h6000, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard stop so a wedged design still produces a verdict.
   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
